// File: rtl/sram_req_arbiter.sv
// Two-requester arbiter (inst fetch / data path) onto one SRAM-like port.
// Holds the grant through the address handshake and routes in-order responses by an owner FIFO.
module sram_req_arbiter #(
    parameter int unsigned MAX_OUT      = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inst_req,
    input  logic                     inst_wr,
    input  logic [1:0]               inst_size,
    input  logic [3:0]               inst_wstrb,
    input  logic [31:0]              inst_addr,
    input  logic [31:0]              inst_wdata,
    output logic                     inst_addr_ok,
    output logic                     inst_data_ok,
    output logic [31:0]              inst_rdata,
    input  logic                     data_req,
    input  logic                     data_wr,
    input  logic [1:0]               data_size,
    input  logic [3:0]               data_wstrb,
    input  logic [31:0]              data_addr,
    input  logic [31:0]              data_wdata,
    output logic                     data_addr_ok,
    output logic                     data_data_ok,
    output logic [31:0]              data_rdata,
    output logic                     mem_req,
    output logic                     mem_wr,
    output logic [1:0]               mem_size,
    output logic [3:0]               mem_wstrb,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_addr_ok,
    input  logic                     mem_data_ok,
    input  logic [31:0]              mem_rdata,
    output logic [$clog2(MAX_OUT):0] outstanding,
    output logic                     err_spurious
);

    localparam int unsigned PW = $clog2(MAX_OUT);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    // Owner encoding: 0 = inst, 1 = data
    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [MAX_OUT-1:0] fifo_q, fifo_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              err_q, err_d;

    logic gnt_vld, gnt_id;
    logic full, empty, head, push, pop;

    assign full  = (cnt_q == CW'(MAX_OUT));
    assign empty = (cnt_q == CW'(0));
    assign head  = fifo_q[rd_ptr_q];
    assign push  = mem_req && mem_addr_ok;
    assign pop   = mem_data_ok && !empty;

    assign outstanding  = cnt_q;
    assign err_spurious = err_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req && !mem_addr_ok) begin
                    state_d = S_HOLD;
                    owner_d = gnt_id;
                end
            end
            S_HOLD: begin
                if (mem_addr_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: grant selection, request mux and response routing
    always_comb begin
        gnt_vld      = 1'b0;
        gnt_id       = 1'b0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = 2'd0;
        mem_wstrb    = 4'd0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        data_rdata   = 32'd0;

        if (state_q == S_HOLD) begin
            gnt_vld = 1'b1;
            gnt_id  = owner_q;
        end else if (!full) begin
            if (data_req && (!inst_req || starve_q < SW'(STARVE_LIMIT))) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end else if (inst_req) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end
        end

        if (gnt_vld && !reset) begin
            if (gnt_id) begin
                mem_req      = data_req;
                mem_wr       = data_wr;
                mem_size     = data_size;
                mem_wstrb    = data_wstrb;
                mem_addr     = data_addr;
                mem_wdata    = data_wdata;
                data_addr_ok = mem_addr_ok;
            end else begin
                mem_req      = inst_req;
                mem_wr       = inst_wr;
                mem_size     = inst_size;
                mem_wstrb    = inst_wstrb;
                mem_addr     = inst_addr;
                mem_wdata    = inst_wdata;
                inst_addr_ok = mem_addr_ok;
            end
        end

        if (pop && !reset) begin
            if (head) begin
                data_data_ok = 1'b1;
                data_rdata   = mem_rdata;
            end else begin
                inst_data_ok = 1'b1;
                inst_rdata   = mem_rdata;
            end
        end
    end

    // Owner FIFO, outstanding count, starvation counter and error flag
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        err_d    = err_q;

        if (push) begin
            fifo_d[wr_ptr_q] = gnt_id;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (!inst_req) begin
            starve_d = SW'(0);
        end else if (push && !gnt_id) begin
            starve_d = SW'(0);
        end else if (push && gnt_id && starve_q < SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end

        if (mem_data_ok && empty) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: arbitration, starvation, hold, full FIFO, routing, errors.
module tb_sram_req_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [2:0]  outstanding;
    logic        err_spurious;

    int tests_run = 0;
    int tests_failed = 0;

    sram_req_arbiter #(.MAX_OUT(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outstanding(outstanding), .err_spurious(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
    endtask

    // Inputs change 1 time unit after posedge; checks happen at the following negedge
    task automatic settle();
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        #2;
        inst_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_inst_addr_ok", inst_addr_ok, 0);
        check("rst_inst_data_ok", inst_data_ok, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err_spurious, 0);
        clear_inputs();
        tick();
        reset = 1'b0;

        // Single inst read
        inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
        settle();
        check("t1_mem_req", mem_req, 1);
        check("t1_mem_addr", mem_addr, 32'h1C00_0000);
        check("t1_inst_addr_ok", inst_addr_ok, 1);
        check("t1_data_addr_ok", data_addr_ok, 0);
        tick();
        clear_inputs();
        settle();
        check("t1_outstanding", outstanding, 1);
        tick();
        mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
        settle();
        check("t1_inst_data_ok", inst_data_ok, 1);
        check("t1_inst_rdata", inst_rdata, 32'hDEAD_BEEF);
        check("t1_data_data_ok", data_data_ok, 0);
        tick();
        clear_inputs();
        settle();
        check("t1_drained", outstanding, 0);
        tick();

        // Starvation: 8 data grants, then inst, then data again
        for (int k = 0; k < 10; k++) begin
            inst_req = 1; inst_addr = 32'h100;
            data_req = 1; data_addr = 32'h200;
            mem_addr_ok = 1; mem_data_ok = (k > 0);
            settle();
            check($sformatf("t2_data_ok_%0d", k), data_addr_ok, (k != 8));
            check($sformatf("t2_inst_ok_%0d", k), inst_addr_ok, (k == 8));
            check($sformatf("t2_addr_%0d", k), mem_addr, (k == 8) ? 32'h100 : 32'h200);
            if (k == 5) check("t2_push_pop_cnt", outstanding, 1);
            tick();
        end
        clear_inputs();
        mem_data_ok = 1;
        settle();
        check("t2_last_is_data", data_data_ok, 1);
        tick();
        clear_inputs();
        settle();
        check("t2_drained", outstanding, 0);
        tick();

        // Grant hold: data write stalls 3 cycles, inst arrives in cycle 1
        for (int k = 0; k < 4; k++) begin
            data_req = 1; data_wr = 1; data_addr = 32'h300; data_wdata = 32'hCAFE_F00D;
            data_wstrb = 4'hF; data_size = 2'd2;
            inst_req = (k >= 1); inst_addr = 32'h400;
            mem_addr_ok = (k == 3);
            settle();
            check($sformatf("t3_addr_%0d", k), mem_addr, 32'h300);
            check($sformatf("t3_inst_ok_%0d", k), inst_addr_ok, 0);
            check($sformatf("t3_data_ok_%0d", k), data_addr_ok, (k == 3));
            tick();
        end
        check("t3_mem_wr_hold", 1'b1, 1'b1 & data_wr);
        data_req = 0; data_wr = 0;
        inst_req = 1; mem_addr_ok = 1;
        settle();
        check("t3_inst_after", inst_addr_ok, 1);
        check("t3_inst_addr", mem_addr, 32'h400);
        check("t3_mem_wr", mem_wr, 0);
        tick();
        clear_inputs();
        mem_data_ok = 1; mem_rdata = 32'hA1;
        settle();
        check("t3_resp0_data", data_data_ok, 1);
        check("t3_resp0_rdata", data_rdata, 32'hA1);
        tick();
        mem_rdata = 32'hA2;
        settle();
        check("t3_resp1_inst", inst_data_ok, 1);
        check("t3_resp1_no_data", data_data_ok, 0);
        tick();
        clear_inputs();
        settle();
        check("t3_drained", outstanding, 0);
        tick();

        // Full FIFO
        for (int k = 0; k < 4; k++) begin
            data_req = 1; data_addr = 32'h500 + 32'(k * 4); mem_addr_ok = 1;
            settle();
            check($sformatf("t4_acc_%0d", k), data_addr_ok, 1);
            tick();
        end
        mem_data_ok = 1;
        settle();
        check("t4_full_cnt", outstanding, 4);
        check("t4_full_no_req", mem_req, 0);
        check("t4_full_no_ok", data_addr_ok, 0);
        check("t4_pop_resp", data_data_ok, 1);
        tick();
        mem_data_ok = 0;
        settle();
        check("t4_after_pop", outstanding, 3);
        check("t4_regrant", mem_req, 1);
        check("t4_regrant_ok", data_addr_ok, 1);
        tick();
        clear_inputs();
        mem_data_ok = 1;
        for (int k = 0; k < 4; k++) tick();
        clear_inputs();
        settle();
        check("t4_drained", outstanding, 0);
        tick();

        // Interleaved responses; cycle 2 pushes and pops together
        inst_req = 1; inst_addr = 32'h600; mem_addr_ok = 1;
        tick();
        inst_req = 0; data_req = 1; data_addr = 32'h700;
        tick();
        data_req = 0; inst_req = 1; inst_addr = 32'h604;
        mem_data_ok = 1; mem_rdata = 32'h11;
        settle();
        check("t5_cnt_before", outstanding, 2);
        check("t5_r0_inst", inst_data_ok, 1);
        check("t5_r0_rdata", inst_rdata, 32'h11);
        check("t5_push_ok", inst_addr_ok, 1);
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_rdata = 32'h22;
        settle();
        check("t5_cnt_same", outstanding, 2);
        check("t5_r1_data", data_data_ok, 1);
        check("t5_r1_rdata", data_rdata, 32'h22);
        check("t5_r1_no_inst", inst_data_ok, 0);
        tick();
        mem_rdata = 32'h33;
        settle();
        check("t5_r2_inst", inst_data_ok, 1);
        check("t5_r2_rdata", inst_rdata, 32'h33);
        tick();
        clear_inputs();
        settle();
        check("t5_drained", outstanding, 0);
        check("t5_no_err", err_spurious, 0);
        tick();

        // Spurious response
        mem_data_ok = 1; mem_rdata = 32'h55;
        settle();
        check("t6_no_inst_ok", inst_data_ok, 0);
        check("t6_no_data_ok", data_data_ok, 0);
        tick();
        clear_inputs();
        settle();
        check("t6_err_set", err_spurious, 1);
        tick();
        settle();
        check("t6_err_sticky", err_spurious, 1);
        tick();

        // Reset with two outstanding, then a stale response
        inst_req = 1; inst_addr = 32'h800; mem_addr_ok = 1;
        tick();
        tick();
        clear_inputs();
        settle();
        check("t7_cnt2", outstanding, 2);
        reset = 1'b1;
        #1;
        check("t7_cnt_reset", outstanding, 0);
        check("t7_err_reset", err_spurious, 0);
        tick();
        reset = 1'b0;
        mem_data_ok = 1;
        settle();
        check("t7_stale_no_ok", inst_data_ok, 0);
        tick();
        clear_inputs();
        settle();
        check("t7_stale_err", err_spurious, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
